// File: rtl/mux_scan_pkg.sv
// Shared types and default constants for the mux scan/capture self-check.
package mux_scan_pkg;

    localparam int unsigned NCH_DEF    = 4;
    localparam int unsigned SEL_W_DEF  = 2;
    localparam int unsigned SETTLE_DEF = 2;
    localparam int unsigned ERR_W_DEF  = 8;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_DONE   = 2'd2
    } state_e;

    // Width of a down-counter that must hold settle-1 (never narrower than 1 bit).
    function automatic int unsigned cnt_width(input int unsigned settle);
        return (settle > 1) ? $clog2(settle) : 1;
    endfunction

endpackage

// File: rtl/scan_settle_timer.sv
// Settle-window down-counter: loads SETTLE-1, counts down to zero and holds there.
module scan_settle_timer
    import mux_scan_pkg::*;
#(
    parameter int unsigned SETTLE = SETTLE_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic load_i,
    input  logic dec_i,
    output logic zero_o
);

    localparam int unsigned CNT_W = cnt_width(SETTLE);
    localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(SETTLE - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Next count: load wins over decrement; zero is sticky until reloaded.
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = LOAD_VAL;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    // Count register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/mux_scan_capture.sv
// Walks every mux select, samples y after a settle window, rebuilds the input
// word, compares it with the latched expectation and reports via valid/ready.
module mux_scan_capture
    import mux_scan_pkg::*;
#(
    parameter int unsigned NCH    = NCH_DEF,
    parameter int unsigned SEL_W  = SEL_W_DEF,
    parameter int unsigned SETTLE = SETTLE_DEF,
    parameter int unsigned ERR_W  = ERR_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [NCH-1:0]   exp,
    output logic [SEL_W-1:0] sel,
    input  logic             y,
    output logic [NCH-1:0]   word,
    output logic             valid,
    input  logic             ready,
    output logic             busy,
    output logic             mismatch,
    output logic [ERR_W-1:0] err_cnt
);

    localparam logic [SEL_W-1:0] LAST_SEL = SEL_W'(NCH - 1);

    state_e           state_q;
    logic [SEL_W-1:0] sel_q;
    logic [NCH-1:0]   acc_q;
    logic [NCH-1:0]   exp_q;
    logic [NCH-1:0]   word_q;
    logic             valid_q;
    logic             busy_q;
    logic             mismatch_q;
    logic [ERR_W-1:0] err_q;

    logic             tmr_zero;
    logic             tmr_load;
    logic             tmr_dec;
    logic             last_sel;
    logic [NCH-1:0]   acc_smp;
    logic             smp_mismatch;

    assign last_sel = (sel_q == LAST_SEL);

    // Timer reloads on launch and on every channel advance; counts down only while settling.
    assign tmr_load = ((state_q == ST_IDLE) && start) ||
                      ((state_q == ST_SETTLE) && tmr_zero && !last_sel);
    assign tmr_dec  = (state_q == ST_SETTLE) && !tmr_zero;

    scan_settle_timer #(
        .SETTLE (SETTLE)
    ) u_timer (
        .clk    (clk),
        .rst    (rst),
        .load_i (tmr_load),
        .dec_i  (tmr_dec),
        .zero_o (tmr_zero)
    );

    // Accumulator as it would look with the current y folded in at bit sel.
    always_comb begin
        acc_smp        = acc_q;
        acc_smp[sel_q] = y;
        smp_mismatch   = (acc_smp != exp_q);
    end

    // Scan sequencer with registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            sel_q      <= '0;
            acc_q      <= '0;
            exp_q      <= '0;
            word_q     <= '0;
            valid_q    <= 1'b0;
            busy_q     <= 1'b0;
            mismatch_q <= 1'b0;
            err_q      <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        exp_q   <= exp;
                        sel_q   <= '0;
                        acc_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= ST_SETTLE;
                    end
                end
                ST_SETTLE: begin
                    if (tmr_zero) begin
                        acc_q <= acc_smp;
                        if (!last_sel) begin
                            sel_q <= sel_q + SEL_W'(1);
                        end else begin
                            word_q     <= acc_smp;
                            mismatch_q <= smp_mismatch;
                            if (smp_mismatch && (err_q != '1)) begin
                                err_q <= err_q + ERR_W'(1);
                            end
                            valid_q <= 1'b1;
                            state_q <= ST_DONE;
                        end
                    end
                end
                ST_DONE: begin
                    if (ready) begin
                        valid_q    <= 1'b0;
                        mismatch_q <= 1'b0;
                        sel_q      <= '0;
                        busy_q     <= 1'b0;
                        state_q    <= ST_IDLE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign sel      = sel_q;
    assign word     = word_q;
    assign valid    = valid_q;
    assign busy     = busy_q;
    assign mismatch = mismatch_q;
    assign err_cnt  = err_q;

endmodule

// File: tb/tb_mux_scan_capture.sv
// Bench for mux_scan_capture: a 4:1 mux model closes the loop; a second
// instance with a 2-bit error counter shares the stimulus to exercise saturation.
module tb_mux_scan_capture;

    localparam int NCH_T    = 4;
    localparam int SETTLE_T = 2;
    localparam int SCAN_CYC = NCH_T * SETTLE_T;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       ready;
    logic       stuck;
    logic [3:0] mux_i;
    logic [3:0] exp_w;

    logic [1:0] sel,  sel2;
    logic       y,    y2;
    logic [3:0] word, word2;
    logic       valid, valid2;
    logic       busy,  busy2;
    logic       mismatch, mismatch2;
    logic [7:0] err_cnt;
    logic [1:0] err_cnt2;

    int total = 0;
    int bad   = 0;
    int err8_m = 0;
    int err2_m = 0;

    // Mux under test: input word mux_i, optionally stuck-at-0 output.
    assign y  = stuck ? 1'b0 : mux_i[sel];
    assign y2 = stuck ? 1'b0 : mux_i[sel2];

    always #5 clk = ~clk;

    mux_scan_capture #(.NCH(4), .SEL_W(2), .SETTLE(2), .ERR_W(8)) dut (
        .clk(clk), .rst(rst), .start(start), .exp(exp_w), .sel(sel), .y(y),
        .word(word), .valid(valid), .ready(ready), .busy(busy),
        .mismatch(mismatch), .err_cnt(err_cnt)
    );

    mux_scan_capture #(.NCH(4), .SEL_W(2), .SETTLE(2), .ERR_W(2)) dut_sat (
        .clk(clk), .rst(rst), .start(start), .exp(exp_w), .sel(sel2), .y(y2),
        .word(word2), .valid(valid2), .ready(ready), .busy(busy2),
        .mismatch(mismatch2), .err_cnt(err_cnt2)
    );

    // One complete scan; hold = DONE cycles with ready low, poke = start asserted in DONE.
    task automatic do_scan(input logic [3:0] i_v, input logic [3:0] e_v,
                           input logic stuck_v, input int hold, input logic poke);
        logic [3:0] w_exp;
        logic       mm_exp;
        mux_i = i_v; exp_w = e_v; stuck = stuck_v; ready = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int n = 0; n < SCAN_CYC; n++) begin
            total++;
            if (sel !== 2'(n / SETTLE_T) || busy !== 1'b1 || valid !== 1'b0 || sel2 !== sel) begin
                bad++;
                $display("FAIL scan_seq n=%0d: sel=%0d sel2=%0d busy=%b valid=%b, want sel=%0d busy=1 valid=0",
                         n, sel, sel2, busy, valid, n / SETTLE_T);
            end
            exp_w = 4'($urandom);
            if (n == 3) ready = 1'b1;
            @(negedge clk);
            ready = 1'b0;
        end
        w_exp  = stuck_v ? 4'b0000 : i_v;
        mm_exp = (w_exp != e_v);
        if (mm_exp) begin
            err8_m = (err8_m < 255) ? err8_m + 1 : 255;
            err2_m = (err2_m < 3)   ? err2_m + 1 : 3;
        end
        total++;
        if (valid !== 1'b1 || word !== w_exp || mismatch !== mm_exp || err_cnt !== 8'(err8_m) ||
            valid2 !== 1'b1 || word2 !== w_exp || err_cnt2 !== 2'(err2_m)) begin
            bad++;
            $display("FAIL scan_result: valid=%b word=%b mm=%b err=%0d valid2=%b word2=%b err2=%0d, want valid=1 word=%b mm=%b err=%0d err2=%0d",
                     valid, word, mismatch, err_cnt, valid2, word2, err_cnt2, w_exp, mm_exp, err8_m, err2_m);
        end
        for (int d = 0; d < hold; d++) begin
            start = poke;
            exp_w = 4'($urandom);
            @(negedge clk);
            start = 1'b0;
            total++;
            if (valid !== 1'b1 || word !== w_exp || mismatch !== mm_exp || busy !== 1'b1 || sel !== 2'(NCH_T - 1)) begin
                bad++;
                $display("FAIL done_hold d=%0d: valid=%b word=%b mm=%b busy=%b sel=%0d, want 1 %b %b 1 3",
                         d, valid, word, mismatch, busy, sel, w_exp, mm_exp);
            end
        end
        ready = 1'b1; start = poke;
        @(negedge clk);
        ready = 1'b0; start = 1'b0;
        total++;
        if (valid !== 1'b0 || mismatch !== 1'b0 || busy !== 1'b0 || sel !== 2'd0 || word !== w_exp) begin
            bad++;
            $display("FAIL handshake: valid=%b mm=%b busy=%b sel=%0d word=%b, want 0 0 0 0 %b",
                     valid, mismatch, busy, sel, word, w_exp);
        end
        if (poke) begin
            for (int d = 0; d < 4; d++) begin
                @(negedge clk);
                total++;
                if (busy !== 1'b0 || valid !== 1'b0 || sel !== 2'd0) begin
                    bad++;
                    $display("FAIL no_relaunch d=%0d: busy=%b valid=%b sel=%0d, want 0 0 0", d, busy, valid, sel);
                end
            end
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        total++;
        if (sel !== 2'd0 || word !== 4'd0 || valid !== 1'b0 || busy !== 1'b0 ||
            mismatch !== 1'b0 || err_cnt !== 8'd0 || err_cnt2 !== 2'd0) begin
            bad++;
            $display("FAIL reset_async: sel=%0d word=%b valid=%b busy=%b mm=%b err=%0d, want all 0",
                     sel, word, valid, busy, mismatch, err_cnt);
        end
        @(negedge clk);
        rst = 1'b0;
        for (int n = 0; n < 3; n++) begin
            @(negedge clk);
            total++;
            if (sel !== 2'd0 || valid !== 1'b0 || busy !== 1'b0 || word !== 4'd0) begin
                bad++;
                $display("FAIL reset_idle n=%0d: sel=%0d valid=%b busy=%b word=%b, want 0", n, sel, valid, busy, word);
            end
        end
        err8_m = 0; err2_m = 0;
    endtask

    task automatic test_clean();
        do_scan(4'b1010, 4'b1010, 1'b0, 0, 1'b0);
    endtask

    task automatic test_fault();
        do_scan(4'b1111, 4'b1111, 1'b1, 1, 1'b0);
        do_scan(4'b1111, 4'b1111, 1'b1, 0, 1'b0);
        total++;
        if (err_cnt !== 8'd2) begin
            bad++;
            $display("FAIL fault_count: err_cnt=%0d, want 2", err_cnt);
        end
    endtask

    task automatic test_backpressure();
        do_scan(4'b0011, 4'b0111, 1'b0, 5, 1'b1);
    endtask

    task automatic test_random();
        for (int r = 0; r < 8; r++) begin
            logic [3:0] iv, ev;
            iv = 4'($urandom);
            ev = ($urandom_range(0, 1) == 0) ? iv : 4'($urandom);
            do_scan(iv, ev, ($urandom_range(0, 3) == 0), $urandom_range(0, 3), 1'($urandom_range(0, 1)));
        end
    endtask

    task automatic test_midscan_reset();
        mux_i = 4'b1010; exp_w = 4'b0101; stuck = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int n = 0; n < 2 * SETTLE_T; n++) @(negedge clk);
        total++;
        if (sel !== 2'd2 || busy !== 1'b1) begin
            bad++;
            $display("FAIL midscan_pre: sel=%0d busy=%b, want 2 1", sel, busy);
        end
        #2 rst = 1'b1;
        #1;
        err8_m = 0; err2_m = 0;
        total++;
        if (sel !== 2'd0 || word !== 4'd0 || valid !== 1'b0 || busy !== 1'b0 ||
            mismatch !== 1'b0 || err_cnt !== 8'd0 || err_cnt2 !== 2'd0 || busy2 !== 1'b0) begin
            bad++;
            $display("FAIL midscan_reset: sel=%0d word=%b valid=%b busy=%b mm=%b err=%0d err2=%0d, want all 0",
                     sel, word, valid, busy, mismatch, err_cnt, err_cnt2);
        end
        @(negedge clk);
        rst = 1'b0;
        for (int n = 0; n < 12; n++) begin
            @(negedge clk);
            total++;
            if (valid !== 1'b0 || busy !== 1'b0) begin
                bad++;
                $display("FAIL abandoned n=%0d: valid=%b busy=%b, want 0 0", n, valid, busy);
            end
        end
        do_scan(4'b0110, 4'b0110, 1'b0, 0, 1'b0);
    endtask

    task automatic test_saturation();
        int want [5] = '{1, 2, 3, 3, 3};
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        err8_m = 0; err2_m = 0;
        for (int s = 0; s < 5; s++) begin
            do_scan(4'b0000, 4'b1111, 1'b0, 0, 1'b0);
            total++;
            if (err_cnt2 !== 2'(want[s]) || err_cnt !== 8'(s + 1)) begin
                bad++;
                $display("FAIL saturation s=%0d: err2=%0d err8=%0d, want %0d %0d", s, err_cnt2, err_cnt, want[s], s + 1);
            end
        end
    endtask

    initial begin
        rst = 1'b0; start = 1'b0; ready = 1'b0; stuck = 1'b0;
        mux_i = 4'd0; exp_w = 4'd0;
        test_reset();
        test_clean();
        test_fault();
        test_backpressure();
        test_random();
        test_midscan_reset();
        test_saturation();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mux_scan_capture.md
Name: mux_scan_capture

Overview:
- Sequencer that sits directly upstream and downstream of the 4:1 mux. It drives the mux select lines and samples the mux output after a settle window.
- It walks all channels in order, reassembles the mux input word, compares it against an expected word, and counts mismatches.
- It hands the result to a consumer through a valid/ready handshake.
- Used as the on-chip self-check for the mux: a hardware version of the random select/compare loop.

Parameters:
- NCH, 4, number of mux channels; power of two, at least 2.
- SEL_W, 2, select width; must equal log2(NCH).
- SETTLE, 2, cycles each select value is held before sampling; at least 1.
- ERR_W, 8, width of the saturating mismatch counter.

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  begin a scan; sampled only in IDLE.
- exp  input  NCH  expected mux input word; latched on an accepted start.
- sel  output  SEL_W  registered select driven to the mux.
- y  input  1  mux output; combinational function of sel.
- word  output  NCH  captured word; bit j is y sampled while sel==j.
- valid  output  1  word and mismatch are valid.
- ready  input  1  consumer accepts the result.
- busy  output  1  high whenever state is not IDLE.
- mismatch  output  1  word differed from the latched exp; qualified by valid.
- err_cnt  output  ERR_W  saturating count of mismatching scans.

Behaviour:
- Reset (async, immediate): state=IDLE; sel=0, word=0, valid=0, busy=0, mismatch=0, err_cnt=0. Internal accumulator, settle counter and exp_q are cleared.
- States: IDLE, SETTLE, DONE.
- IDLE → SETTLE: start high at edge k.
  - exp_q<=exp, sel<=0, cnt<=SETTLE-1, accumulator<=0.
- In SETTLE:
  - cnt!=0: cnt decrements; sel is held.
  - cnt==0: acc[sel]<=y.
  - If sel!=NCH-1: sel<=sel+1 and cnt<=SETTLE-1.
  - Else (same edge): word<=final acc including this sample; mismatch<=(final acc!=exp_q); err_cnt increments if mismatch, saturating at all-ones; valid<=1; state<=DONE.
- Timing: channel j is sampled at edge k+(j+1)*SETTLE, so valid rises at edge k+NCH*SETTLE.
  - Defaults: 8 cycles.
  - sel sequence over those cycles is 0,0,1,1,2,2,3,3.
- sel stays at NCH-1 in DONE and returns to 0 on re-entering IDLE.
- DONE:
  - word, mismatch and valid hold stable until ready is high at an edge.
  - On that edge: valid<=0, mismatch<=0, state<=IDLE. word keeps its last value.
- start:
  - Ignored in SETTLE and DONE, including when start and ready are high on the same edge in DONE.
  - Must be high again in IDLE to launch the next scan; there is no back-to-back launch.
- ready is ignored outside DONE.
- Any change on exp after start has no effect on the current scan.
- Reset mid-scan: the scan is abandoned and all outputs go to reset values. valid never rises for the abandoned scan. err_cnt is cleared too.
- No combinational path from inputs to outputs; all outputs are registered.

Decomposition:
- Package mux_scan_pkg holds:
  - the state typedef (IDLE, SETTLE, DONE);
  - default constants for NCH, SEL_W, SETTLE, ERR_W.
- One natural sub-module, scan_settle_timer: a down-counter with load and a zero flag, parameterised by SETTLE.
- Everything else stays inline.
- The 4:1 mux itself is instantiated only in the bench, with sel wired to its select and its output to y.

Test Plan:
1. Reset: assert rst mid-cycle → all outputs 0 immediately; release with start=0 → outputs stay 0, busy=0.
2. Clean scan: mux i=4'b1010, exp=4'b1010, start pulse → sel 0,0,1,1,2,2,3,3; valid after 8 edges; word=1010, mismatch=0, err_cnt=0; ready → valid drops next edge.
3. Fault: y forced stuck-at-0, i=exp=4'b1111 → word=0000, mismatch=1, err_cnt=1; a second faulty scan → err_cnt=2.
4. Backpressure: ready low for 5 cycles after valid → word/mismatch/valid stable. start pulsed during DONE and together with ready → ignored, busy=0 after handshake, no new scan.
5. Reset mid-scan: rst while sel=2 → outputs 0 at once, valid never rises; next start with i=exp=4'b0110 → word=0110, mismatch=0.
6. Saturation: ERR_W=2, five scans with i=4'b0000 and exp=4'b1111 → err_cnt 1,2,3,3,3.
